// File: rtl/ife_param.sv
// Parametrised 3x3 image filter engine: raster walk over a 2^LOG_W x 2^LOG_H ROM image,
// one of mean/median/max/min/threshold per pixel. Edge replication: IFE_EDGE_REPLICATE_EN.
module ife_param #(
    parameter int DW    = 8,
    parameter int LOG_W = 7,
    parameter int LOG_H = 7,
    localparam int AW   = LOG_W + LOG_H
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic [2:0]    sel,
    input  logic [DW-1:0] thr,
    output logic          busy,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_wr,
    output logic          wen
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, WRITE} state_t;

    state_t          st;
    logic [3:0]      k;
    logic [AW-1:0]   pix;
    logic [2:0]      sel_q;
    logic [DW-1:0]   thr_q;
    logic [DW+3:0]   sum;
    logic [DW-1:0]   mx, mn, cen;
    logic [DW-1:0]   srt [9];

    logic            cons;
    logic [3:0]      ctap;
    logic [DW-1:0]   smp;
    logic [DW+3:0]   sum_n;
    logic [DW-1:0]   mx_n, mn_n, cen_n;
    logic [DW-1:0]   srt_n [9];
    logic [DW-1:0]   result;
    logic [AW-1:0]   nxt_iaddr;
    logic [AW-1:0]   nxt_pix;
    logic [3:0]      nxt_tap;

    // Tap t of the 3x3 window, row-major: row offset = t/3 - 1, col offset = t%3 - 1.
    function automatic logic [1:0] tap_row(input logic [3:0] t);
        case (t)
            4'd0, 4'd1, 4'd2: return 2'd0;
            4'd3, 4'd4, 4'd5: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] tap_col(input logic [3:0] t);
        case (t)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] p, input logic [3:0] t);
        logic [LOG_H-1:0] r;
        logic [LOG_W-1:0] c;
        r = p[AW-1:LOG_W];
        c = p[LOG_W-1:0];
        if (tap_row(t) == 2'd0 && r != '0)      r = r - 1'b1;
        else if (tap_row(t) == 2'd2 && r != '1) r = r + 1'b1;
        if (tap_col(t) == 2'd0 && c != '0)      c = c - 1'b1;
        else if (tap_col(t) == 2'd2 && c != '1) c = c + 1'b1;
        return {r, c};
    endfunction

`ifndef IFE_EDGE_REPLICATE_EN
    function automatic logic tap_oob(input logic [AW-1:0] p, input logic [3:0] t);
        logic [LOG_H-1:0] r;
        logic [LOG_W-1:0] c;
        r = p[AW-1:LOG_W];
        c = p[LOG_W-1:0];
        return (tap_row(t) == 2'd0 && r == '0) || (tap_row(t) == 2'd2 && r == '1) ||
               (tap_col(t) == 2'd0 && c == '0) || (tap_col(t) == 2'd2 && c == '1);
    endfunction
`endif

    always_comb begin
        cons = (st == FETCH && k != 4'd0) || st == CAPTURE;
        ctap = (st == CAPTURE) ? 4'd8 : k - 4'd1;
`ifdef IFE_EDGE_REPLICATE_EN
        smp = idata;
`else
        smp = tap_oob(pix, ctap) ? '0 : idata;
`endif
        sum_n = sum + (DW+4)'(smp);
        mx_n  = (smp > mx) ? smp : mx;
        mn_n  = (smp < mn) ? smp : mn;
        cen_n = (ctap == 4'd4) ? smp : cen;

        // Descending insertion; a new sample lands below any equal entries.
        srt_n[0] = (srt[0] >= smp) ? srt[0] : smp;
        for (int i = 1; i < 9; i++) begin
            if (srt[i] >= smp)          srt_n[i] = srt[i];
            else if (srt[i-1] >= smp)   srt_n[i] = smp;
            else                        srt_n[i] = srt[i-1];
        end

        case (sel_q)
            3'd0:    result = DW'(sum_n / (DW+4)'(9));
            3'd1:    result = srt_n[4];
            3'd2:    result = mx_n;
            3'd3:    result = mn_n;
            3'd4:    result = (cen_n >= thr_q) ? cen_n : '0;
            default: result = '0;
        endcase

        nxt_pix   = (st == WRITE) ? AW'(pix + 1'b1) : pix;
        nxt_tap   = (st == WRITE) ? 4'd0 : k + 4'd1;
        nxt_iaddr = tap_addr(nxt_pix, nxt_tap);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= IDLE;
            k       <= '0;
            pix     <= '0;
            sel_q   <= '0;
            thr_q   <= '0;
            sum     <= '0;
            mx      <= '0;
            mn      <= '0;
            cen     <= '0;
            for (int i = 0; i < 9; i++) srt[i] <= '0;
            busy    <= 1'b0;
            iaddr   <= '0;
            addr    <= '0;
            data_wr <= '0;
            wen     <= 1'b0;
        end else begin
            if (st == FETCH && k == 4'd0) begin
                sum <= '0;
                mx  <= '0;
                mn  <= '1;
                cen <= '0;
                for (int i = 0; i < 9; i++) srt[i] <= '0;
            end else if (cons) begin
                sum <= sum_n;
                mx  <= mx_n;
                mn  <= mn_n;
                cen <= cen_n;
                for (int i = 0; i < 9; i++) srt[i] <= srt_n[i];
            end

            case (st)
                IDLE: begin
                    wen     <= 1'b0;
                    addr    <= '0;
                    data_wr <= '0;
                    if (ready) begin
                        sel_q <= sel;
                        thr_q <= thr;
                        pix   <= '0;
                        k     <= '0;
                        iaddr <= '0;
                        busy  <= 1'b1;
                        st    <= FETCH;
                    end
                end
                FETCH: begin
                    if (k == 4'd8) begin
                        st <= CAPTURE;
                    end else begin
                        k     <= k + 4'd1;
                        iaddr <= nxt_iaddr;
                    end
                end
                CAPTURE: begin
                    wen     <= 1'b1;
                    addr    <= pix;
                    data_wr <= result;
                    k       <= '0;
                    st      <= WRITE;
                end
                WRITE: begin
                    wen     <= 1'b0;
                    addr    <= '0;
                    data_wr <= '0;
                    k       <= '0;
                    if (pix == '1) begin
                        busy <= 1'b0;
                        st   <= IDLE;
                    end else begin
                        pix   <= nxt_pix;
                        iaddr <= nxt_iaddr;
                        st    <= FETCH;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ife_param.sv
// Self-checking bench for ife_param on an 8x8 image: cycle-level reference of the
// per-pixel schedule and window arithmetic, plus literal pins from hand-computed cases.
module tb_ife_param;

    localparam int DW = 8, LOG_W = 3, LOG_H = 3, AW = 6;
    localparam int W = 8, H = 8, N = 64, FR = 11 * N;
`ifdef IFE_EDGE_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b0;
    logic [2:0]    sel = '0;
    logic [DW-1:0] thr = '0;
    logic          busy, wen;
    logic [AW-1:0] iaddr, addr;
    logic [DW-1:0] idata, data_wr;

    always #5 clk = ~clk;

    ife_param #(.DW(DW), .LOG_W(LOG_W), .LOG_H(LOG_H)) dut (
        .clk(clk), .reset(reset), .ready(ready), .sel(sel), .thr(thr),
        .busy(busy), .iaddr(iaddr), .idata(idata),
        .addr(addr), .data_wr(data_wr), .wen(wen)
    );

    logic [DW-1:0] img [N];
    always @(posedge clk) idata <= img[iaddr];

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(int v, int hi);
        return (v < 0) ? 0 : (v > hi) ? hi : v;
    endfunction

    function automatic int exp_iaddr(int p, int t);
        return clampi(p / W + t / 3 - 1, H - 1) * W + clampi(p % W + t % 3 - 1, W - 1);
    endfunction

    function automatic int exp_val(int p, int s, int th);
        int v[9];
        int r, c, sum, mx, mn, cen, tmp;
        sum = 0; mx = 0; mn = 255;
        for (int t = 0; t < 9; t++) begin
            r = p / W + t / 3 - 1;
            c = p % W + t % 3 - 1;
            if (r < 0 || r >= H || c < 0 || c >= W)
                v[t] = REPL ? int'(img[exp_iaddr(p, t)]) : 0;
            else
                v[t] = int'(img[r * W + c]);
            sum += v[t];
            if (v[t] > mx) mx = v[t];
            if (v[t] < mn) mn = v[t];
        end
        cen = v[4];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp; end
        case (s)
            0: return sum / 9;
            1: return v[4];
            2: return mx;
            3: return mn;
            4: return (cen >= th) ? cen : 0;
            default: return 0;
        endcase
    endfunction

    // Reference: frame runs for FR cycles after the start edge; cycle t is pixel t/11, phase t%11.
    int m_busy = 0, m_t = 0;
    int m_exp [N];
    always @(posedge clk or posedge reset) begin
        if (reset) m_busy = 0;
        else if (m_busy == 0) begin
            if (ready) begin
                m_busy = 1;
                m_t = 0;
                for (int p = 0; p < N; p++) m_exp[p] = exp_val(p, int'(sel), int'(thr));
            end
        end else begin
            m_t++;
            if (m_t == FR) m_busy = 0;
        end
    end

    int  dut_wr [N];
    int  wr_cnt [N];
    bit  chk_en = 1'b0;

    always @(negedge clk) begin
        int ph, px;
        if (chk_en) begin
            chk("busy", busy, m_busy);
            if (reset) begin
                chk("rst_iaddr", iaddr, 0);
                chk("rst_addr", addr, 0);
                chk("rst_data", data_wr, 0);
                chk("rst_wen", wen, 0);
            end else if (m_busy != 0) begin
                ph = m_t % 11;
                px = m_t / 11;
                if (ph < 9) chk("iaddr", iaddr, exp_iaddr(px, ph));
                chk("wen", wen, (ph == 10) ? 1 : 0);
                if (ph == 10) begin
                    chk("addr", addr, px);
                    chk("data_wr", data_wr, m_exp[px]);
                    if (!$isunknown(addr)) begin
                        dut_wr[addr] = int'(data_wr);
                        wr_cnt[addr]++;
                    end
                end else begin
                    chk("addr_idle", addr, 0);
                    chk("data_idle", data_wr, 0);
                end
            end else begin
                chk("wen_idle", wen, 0);
                chk("addr_idle", addr, 0);
                chk("data_idle", data_wr, 0);
            end
        end
    end

    task automatic run_frame(input int s, input int th, input bit pulse);
        int cnt, ok;
        @(posedge clk); #1;
        for (int p = 0; p < N; p++) begin wr_cnt[p] = 0; dut_wr[p] = -1; end
        sel = 3'(s); thr = DW'(th); ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        cnt = 0;
        while (busy && cnt < FR + 20) begin
            ready = (pulse && cnt < FR - 4 && $urandom_range(0, 5) == 0);
            sel = 3'($urandom);
            thr = DW'($urandom);
            @(posedge clk); #1;
            cnt++;
        end
        ready = 1'b0;
        chk("frame_len", cnt, FR);
        ok = 0;
        for (int p = 0; p < N; p++) if (wr_cnt[p] == 1) ok++;
        chk("write_once", ok, N);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input int v);
        for (int p = 0; p < N; p++) img[p] = DW'(v);
    endtask

    task automatic fill_rand();
        for (int p = 0; p < N; p++) img[p] = DW'($urandom);
    endtask

    initial begin
        int cnt;
        fill_const(0);
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Constant 100, mean
        fill_const(100);
        run_frame(0, 0, 1'b0);
        chk("c100_model_p0", m_exp[0], REPL ? 100 : 44);
        chk("c100_p0", dut_wr[0], REPL ? 100 : 44);
        chk("c100_p1", dut_wr[1], REPL ? 100 : 66);
        chk("c100_p8", dut_wr[8], REPL ? 100 : 66);
        chk("c100_p9", dut_wr[9], 100);
        chk("c100_p63", dut_wr[63], REPL ? 100 : 44);
        for (int s = 1; s < 4; s++) begin
            run_frame(s, 0, 1'b0);
            chk("c100_other_p9", dut_wr[9], 100);
        end

        // Single bright pixel at (5,5)
        fill_const(10);
        img[45] = 8'd255;
        run_frame(1, 0, 1'b0);
        chk("spike_med_45", dut_wr[45], 10);
        run_frame(2, 0, 1'b0);
        chk("spike_max_45", dut_wr[45], 255);
        chk("spike_max_36", dut_wr[36], 255);
        chk("spike_max_54", dut_wr[54], 255);
        chk("spike_max_27", dut_wr[27], 10);
        chk("spike_max_0", dut_wr[0], 10);

        // Threshold with ramp by column
        for (int p = 0; p < N; p++) img[p] = DW'((p % W) * 32);
        run_frame(4, 128, 1'b0);
        chk("thr_c3", dut_wr[19], 0);
        chk("thr_c4", dut_wr[20], 128);
        chk("thr_c7", dut_wr[7], 224);

        // Reset at pixel 37 tap 4, then restart
        fill_rand();
        @(posedge clk); #1;
        sel = 3'd0; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        cnt = 0;
        while (!(m_busy != 0 && m_t == 37 * 11 + 4) && cnt < FR) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("reach_p37", (m_busy != 0 && m_t == 37 * 11 + 4) ? 1 : 0, 1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_busy", busy, 0);
        run_frame(0, 0, 1'b0);

        // Reserved mode with ready pulses while busy
        run_frame(6, 0, 1'b1);
        chk("rsv_p10", dut_wr[10], 0);

        // Random images and modes
        for (int f = 0; f < 6; f++) begin
            fill_rand();
            run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ife_param.md
# ife_param

Parametrised image filter engine, successor to the fixed 128x128 filter block. It is started by the host's `ready` pulse and walks a `2^LOG_W` x `2^LOG_H` image in raster order, fetching each 3x3 neighbourhood from the image ROM. It computes one of five filters (mean, median, max/dilation, min/erosion, programmable threshold) per pixel and writes one result per pixel into the result RAM.

## Interface
- `DW`, 8: pixel width in bits.
- `LOG_W`, 7: log2 of image width.
- `LOG_H`, 7: log2 of image height; `AW = LOG_W+LOG_H`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ready` in 1: start request; sampled only while idle.
- `sel` in 3: filter mode, latched at start.
  - 0 = mean.
  - 1 = median.
  - 2 = max.
  - 3 = min.
  - 4 = threshold.
  - 5-7 = reserved; these write 0.
- `thr` in DW: threshold, latched at start.
- `busy` out 1: high while a frame is in progress.
- `iaddr` out AW: image ROM address, `row*2^LOG_W+col`.
- `idata` in DW: ROM data for the `iaddr` of the previous cycle.
- `addr` out AW: result RAM address.
- `data_wr` out DW: result data.
- `wen` out 1: result write strobe.

## Operation
- States: IDLE, FETCH, CAPTURE, WRITE.
- IDLE: `busy`=0.
  - `ready`=1 at an edge latches `sel` and `thr`, clears the pixel counter, and enters FETCH.
- FETCH: tap counter k=0..8, nine cycles. Taps are row-major: (r-1,c-1), (r-1,c), (r-1,c+1), (r,c-1), (r,c), (r,c+1), (r+1,c-1), (r+1,c), (r+1,c+1).
  - `iaddr` carries tap k.
  - The sample for tap k-1 is consumed in the same cycle.
- CAPTURE: one cycle; tap 8 is consumed.
- WRITE: one cycle.
  - Asserts `wen`=1, `addr`=pixel index, `data_wr`=result.
  - Then goes to FETCH for the next pixel, or to IDLE after pixel `2^AW-1`.
- Out-of-image taps:
  - `iaddr` is always driven with the coordinate clamped into the image, so it is never out of range.
  - The consumed sample for such a tap is forced to 0.
- Per-pixel accumulators are cleared at tap 0. They are:
  - sum, `DW+4` bits.
  - running max, running min.
  - 9-entry descending insertion sorter; ties are inserted below equal entries.
  - centre register, loaded from tap 4.
- Results:
  - mean = floor(sum/9).
  - median = sorter entry 4.
  - max and min = the running values, including padded zeros.
  - threshold = centre if centre >= `thr`, else 0.
- `ready` while busy is ignored. Changes on `sel` or `thr` while busy have no effect.

## Timing
- Reset values: `busy`=0, `wen`=0, `iaddr`=0, `addr`=0, `data_wr`=0; state IDLE; counters 0.
- Reset mid-frame aborts immediately. No further `wen` until a new `ready`.
- Start sequence:
  - `ready` is sampled at edge E0.
  - In the cycle after E0: `busy`=1, and `iaddr` = pixel 0 tap 0 (clamped to 0).
- Per pixel: exactly 11 cycles (9 FETCH, 1 CAPTURE, 1 WRITE). Full frame: `11*2^AW` cycles; 180224 at defaults.
- ROM latency: fixed at 1 cycle (`idata` for the `iaddr` of cycle n is valid in cycle n+1).
- `wen`, `addr`, `data_wr` come from flops. They are stable for the whole WRITE cycle and low/0 in every other cycle.
- End of frame: `busy` falls in the cycle after the last WRITE. A `ready` at that edge or later starts a new frame.
- Arithmetic: the sum never overflows (`9*(2^DW-1) < 2^(DW+4)`). The divide truncates.

## Configuration
- `IFE_EDGE_REPLICATE_EN`:
  - Defined: an out-of-image tap uses the ROM sample at the clamped coordinate (edge replication). Corner pixels therefore see their nearest in-image neighbours.
  - Undefined (default): out-of-image taps are zero-padded as above.
- `iaddr` sequencing and timing are identical in both builds.

## Test plan
- Constant image, all 100, mean, zero pad. Interior pixels write 100. Pixel 0 (4 valid taps) writes floor(400/9)=44. Edge non-corner pixels (6 valid taps) write 66.
- Same image with `IFE_EDGE_REPLICATE_EN`: every pixel, corners included, writes 100 for mean, median, max and min.
- Image with pixel(5,5)=255 and all others 10, median: pixel(5,5) writes 10. Max mode: all 9 pixels around (5,5) write 255, others 10.
- Threshold, `thr`=128, with image value = `col*2`: columns 0..63 write 0; column c>=64 writes 2c.
- Assert `reset` at pixel 37 tap 4, then restart:
  - `wen` stays low from reset until the restart.
  - The restart rewrites pixel 0 first.
  - The frame completes in exactly 180224 cycles after `busy` rises.
- Reserved `sel`=6: all `2^AW` writes carry 0. `ready` pulses while busy start no second frame, and `addr` goes 0..16383 exactly once.
